// File: rtl/lpif_txrx_pkg.sv
// Shared definitions for the LPIF upstream TX path.
// Field offsets of the 77-bit TX FIFO word, the word struct, and an idle-word builder.
package lpif_txrx_pkg;

  localparam int STATE_LSB  = 0;
  localparam int PROTID_LSB = 4;
  localparam int DATA_LSB   = 6;
  localparam int DVALID_BIT = 70;
  localparam int CRC_LSB    = 71;
  localparam int CRCV_BIT   = 75;
  localparam int VALID_BIT  = 76;
  localparam int WORD_W     = 77;

  // MSB first; matches the offsets above.
  typedef struct packed {
    logic        valid;
    logic        crc_valid;
    logic [3:0]  crc;
    logic        dvalid;
    logic [63:0] data;
    logic [1:0]  protid;
    logic [3:0]  state;
  } ustrm_word_t;

  // Idle word: link state plus the valid bit, every other field zero.
  function automatic ustrm_word_t pack_idle(input logic [3:0] state);
    ustrm_word_t w;
    w       = '0;
    w.valid = 1'b1;
    w.state = state;
    return w;
  endfunction

endpackage

// File: rtl/lpif_txrx_refresh_timer.sv
// Idle refresh timer.
// Ports: clk/rst (sync, active-high), clr (a word was loaded), gen2_mode (period
// select), refresh_due (counter has reached period-1; never set when period is 0).
module lpif_txrx_refresh_timer
  import lpif_txrx_pkg::*;
#(
  parameter int REFRESH_GEN1 = 256,
  parameter int REFRESH_GEN2 = 128,
  parameter int CNT_WIDTH    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic gen2_mode,
  output logic refresh_due
);

  localparam bit EN1 = (REFRESH_GEN1 != 0);
  localparam bit EN2 = (REFRESH_GEN2 != 0);
  localparam logic [CNT_WIDTH-1:0] P1M1 = CNT_WIDTH'(EN1 ? REFRESH_GEN1 - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] P2M1 = CNT_WIDTH'(EN2 ? REFRESH_GEN2 - 1 : 0);

  logic [CNT_WIDTH-1:0] cnt;

  // Saturates so a long stall never wraps back below the threshold.
  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (cnt != '1)      cnt <= cnt + 1'b1;
  end

  // Mode is compared live, so switching modes does not restart the count.
  assign refresh_due = gen2_mode ? (EN2 && (cnt >= P2M1)) : (EN1 && (cnt >= P1M1));

endmodule

// File: rtl/lpif_txrx_ustrm_sched.sv
// Upstream TX scheduler: merges adapter flits and link-state level into one
// 77-bit TX FIFO word held in a single output register.
// Ports: clk_wr/rst_wr (sync, active-high); sched_en gates new loads;
// m_gen2_mode picks the refresh period; ustrm_state is the link-state level;
// dat_* is the flit channel (valid/ready); txfifo_full/txfifo_wr_en/
// txfifo_upstream_data face the TX FIFO; word_cnt counts FIFO writes (wraps);
// stall flags a word held by backpressure.
module lpif_txrx_ustrm_sched
  import lpif_txrx_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int CRC_WIDTH    = 4,
  parameter int REFRESH_GEN1 = 256,
  parameter int REFRESH_GEN2 = 128,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk_wr,
  input  logic                  rst_wr,
  input  logic                  sched_en,
  input  logic                  m_gen2_mode,
  input  logic [3:0]            ustrm_state,
  input  logic                  dat_valid,
  output logic                  dat_ready,
  input  logic [1:0]            dat_protid,
  input  logic [DATA_WIDTH-1:0] dat_data,
  input  logic                  dat_dvalid,
  input  logic [CRC_WIDTH-1:0]  dat_crc,
  input  logic                  dat_crc_valid,
  input  logic                  txfifo_full,
  output logic                  txfifo_wr_en,
  output logic [WORD_W-1:0]     txfifo_upstream_data,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  stall
);

  logic              out_vld;
  ustrm_word_t       word;
  logic [3:0]        last_state;
  logic              free, dirty, refresh_due, load;
  logic [WORD_W-1:0] data_w, nxt_w;

  // Outputs are forced quiet while reset is asserted, even before the
  // register contents have been cleared by the first reset edge.
  assign free         = ~out_vld | ~txfifo_full;
  assign dat_ready    = free & sched_en & ~rst_wr;
  assign txfifo_wr_en = out_vld & ~txfifo_full & ~rst_wr;
  assign stall        = out_vld & txfifo_full & ~rst_wr;
  assign dirty        = (ustrm_state != last_state);
  assign load         = dat_ready & (dat_valid | dirty | refresh_due);

  always_comb begin
    data_w                               = '0;
    data_w[STATE_LSB  +: 4]              = ustrm_state;
    data_w[PROTID_LSB +: 2]              = dat_protid;
    data_w[DATA_LSB   +: DATA_WIDTH]     = dat_data;
    data_w[DVALID_BIT]                   = dat_dvalid;
    data_w[CRC_LSB    +: CRC_WIDTH]      = dat_crc;
    data_w[CRCV_BIT]                     = dat_crc_valid;
    data_w[VALID_BIT]                    = 1'b1;
  end

  assign nxt_w = dat_valid ? data_w : WORD_W'(pack_idle(ustrm_state));

  // Loads only happen when free, so a stalled word is never overwritten;
  // a state change during the stall just leaves dirty set for a follow-up.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      out_vld    <= 1'b0;
      word       <= '0;
      last_state <= 4'h0;
    end else if (load) begin
      out_vld    <= 1'b1;
      word       <= ustrm_word_t'(nxt_w);
      last_state <= ustrm_state;
    end else if (txfifo_wr_en) begin
      out_vld    <= 1'b0;
    end
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr)            word_cnt <= '0;
    else if (txfifo_wr_en) word_cnt <= word_cnt + 1'b1;
  end

  assign txfifo_upstream_data = word;

  lpif_txrx_refresh_timer #(
    .REFRESH_GEN1 (REFRESH_GEN1),
    .REFRESH_GEN2 (REFRESH_GEN2),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_timer (
    .clk         (clk_wr),
    .rst         (rst_wr),
    .clr         (load),
    .gen2_mode   (m_gen2_mode),
    .refresh_due (refresh_due)
  );

endmodule
